// File: rtl/legv8_fetch_stage.sv
// legv8_fetch_stage
// -----------------------------------------------------------------------------
// Instruction-fetch (IF) stage of the LEGv8 five-stage pipeline.
//
// This stage owns the program counter, drives the instruction memory and
// loads the IF/ID pipeline register. It takes a stall from the hazard unit
// and a branch redirect from EX/MEM, and passes instructions on to decode.
// It also copes with instruction-memory wait states. When it fetches an
// all-zero word it treats that as end-of-program, so system-level benches
// can run to completion.
//
// Parameters
//   PC_W      PC / address width in bits
//   RESET_PC  PC value loaded by reset
//   INSTR_W   instruction width in bits
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   imem_addr      out  fetch address (combinational copy of the PC)
//   imem_req       out  fetch request
//   imem_ready     in   imem_rdata is valid this cycle
//   imem_rdata     in   instruction word from memory
//   stall          in   hold PC and IF/ID (load-use hazard)
//   branch_taken   in   redirect request from EX/MEM
//   branch_target  in   redirect address (low two bits are ignored)
//   ifid_valid     out  IF/ID holds a real instruction
//   ifid_pc        out  PC of the IF/ID instruction
//   ifid_instr     out  IF/ID instruction word
//   halted         out  end-of-program reached
//   perf_fetch     out  count of instructions loaded into IF/ID
//   perf_stall     out  count of stalled fetch cycles
//   perf_bubble    out  count of cycles IF/ID received a bubble
//
// Build option
//   FETCH_PERF_CNT_EN  When this macro is defined, the three perf_* counters
//                      are built. They are 32 bits wide and saturate instead
//                      of wrapping. When it is not defined, perf_* are
//                      tied to zero.
// -----------------------------------------------------------------------------
module legv8_fetch_stage #(
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               ifid_valid,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               halted,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_bubble
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 ifid_valid_q, ifid_valid_d;
    logic [PC_W-1:0]      ifid_pc_q, ifid_pc_d;
    logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
    logic                 halted_q;

    // One-cycle strobes telling the IF/ID update (and the perf counters)
    // what happened this cycle.
    logic                 load_valid;
    logic                 load_bubble;

    // Misaligned targets are silently word-aligned. A mask is used here
    // rather than a part-select, so every bit of the port is consumed.
    logic [PC_W-1:0]      target_aligned;

    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(3));
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

    assign target_aligned = branch_target & ALIGN_MASK;

    // Register bank: state, PC, IF/ID and the halted flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            halted_q     <= (state_d == S_HALT);
        end
    end

    // Next-state logic and IF/ID update.
    //
    // The case statement decides what the cycle does. In FETCH/WAIT the
    // branches are listed in priority order: redirect, then stall, then
    // memory not ready, then end-of-program, then a normal fetch.
    //
    // A stall leaves everything at its default value, so the word fetched
    // this cycle is dropped and fetched again later. A bubble clears only
    // ifid_valid; ifid_pc and ifid_instr keep their old contents.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        load_valid   = 1'b0;
        load_bubble  = 1'b0;
        imem_req     = 1'b0;

        case (state_q)
            S_BOOT: begin
                load_bubble = 1'b1;
                state_d     = S_FETCH;
                if (branch_taken) begin
                    pc_d = target_aligned;
                end
            end

            S_FETCH, S_WAIT: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_d        = target_aligned;
                    load_bubble = 1'b1;
                    state_d     = S_FETCH;
                end else if (stall) begin
                    state_d = state_q;
                end else if (!imem_ready) begin
                    load_bubble = 1'b1;
                    state_d     = S_WAIT;
                end else if (imem_rdata == '0) begin
                    load_bubble = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    load_valid = 1'b1;
                    pc_d       = pc_q + PC_STEP;
                    state_d    = S_FETCH;
                end
            end

            S_HALT: begin
                // Only a redirect leaves HALT; stall has no effect here.
                load_bubble = 1'b1;
                if (branch_taken) begin
                    pc_d    = target_aligned;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (load_bubble) begin
            ifid_valid_d = 1'b0;
        end
        if (load_valid) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign halted     = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_bubble_q;
    logic        count_stall;

    // Stall cycles are counted only while actually fetching. This includes
    // cycles where a redirect overrides the stall.
    assign count_stall = stall && ((state_q == S_FETCH) || (state_q == S_WAIT));

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic enable);
        if (enable && (value != 32'hFFFF_FFFF)) begin
            return value + 32'd1;
        end
        return value;
    endfunction

    // Saturating event counters; reset together with the rest of the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q  <= 32'h0;
            perf_stall_q  <= 32'h0;
            perf_bubble_q <= 32'h0;
        end else begin
            perf_fetch_q  <= sat_inc(perf_fetch_q, load_valid);
            perf_stall_q  <= sat_inc(perf_stall_q, count_stall);
            perf_bubble_q <= sat_inc(perf_bubble_q, load_bubble);
        end
    end

    assign perf_fetch  = perf_fetch_q;
    assign perf_stall  = perf_stall_q;
    assign perf_bubble = perf_bubble_q;
`else
    assign perf_fetch  = 32'h0;
    assign perf_stall  = 32'h0;
    assign perf_bubble = 32'h0;
`endif

endmodule

// File: tb/tb_legv8_fetch_stage.sv
// tb_legv8_fetch_stage
// -----------------------------------------------------------------------------
// Self-checking bench for legv8_fetch_stage.
//
// The reference model below describes the stage in terms of its rules
// rather than states: booting, halted, or fetching. Each cycle it applies
// the first rule that matches. First comes a series of directed steps
// covering reset, stall, redirect, wait states, halt, boot-time branch and
// PC wrap. After that comes a randomized run.
// -----------------------------------------------------------------------------
module tb_legv8_fetch_stage;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam logic [31:0] D = 32'h8B02_0020;

    logic               clk;
    logic               reset;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_req;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic               ifid_valid;
    logic [PC_W-1:0]    ifid_pc;
    logic [INSTR_W-1:0] ifid_instr;
    logic               halted;
    logic [31:0]        perf_fetch;
    logic [31:0]        perf_stall;
    logic [31:0]        perf_bubble;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit                 m_known = 0;
    bit                 m_boot;
    bit                 m_halt;
    logic [PC_W-1:0]    m_pc;
    logic               m_valid;
    logic [PC_W-1:0]    m_ipc;
    logic [INSTR_W-1:0] m_instr;
    logic [31:0]        m_fetch, m_stall, m_bubble;

    legv8_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .halted        (halted),
        .perf_fetch    (perf_fetch),
        .perf_stall    (perf_stall),
        .perf_bubble   (perf_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge, using the inputs sampled at that edge.
    task automatic modelStep(input bit rst, input bit stl, input bit br,
                             input logic [PC_W-1:0] tgt, input bit rdy,
                             input logic [INSTR_W-1:0] data);
        logic [PC_W-1:0] aligned;
        aligned = tgt - (tgt % 4);
        if (rst) begin
            m_known = 1; m_boot = 1; m_halt = 0; m_pc = '0;
            m_valid = 0; m_ipc = '0; m_instr = '0;
            m_fetch = 0; m_stall = 0; m_bubble = 0;
        end else if (m_boot) begin
            m_boot = 0; m_valid = 0; m_bubble = satInc(m_bubble);
            if (br) m_pc = aligned;
        end else if (m_halt) begin
            m_valid = 0; m_bubble = satInc(m_bubble);
            if (br) begin m_pc = aligned; m_halt = 0; end
        end else begin
            if (stl) m_stall = satInc(m_stall);
            if (br) begin
                m_pc = aligned; m_valid = 0; m_bubble = satInc(m_bubble);
            end else if (stl) begin
                // everything held
            end else if (!rdy) begin
                m_valid = 0; m_bubble = satInc(m_bubble);
            end else if (data == 0) begin
                m_valid = 0; m_bubble = satInc(m_bubble); m_halt = 1;
            end else begin
                m_valid = 1; m_ipc = m_pc; m_instr = data;
                m_pc = m_pc + 64'd4;
                m_fetch = satInc(m_fetch);
            end
        end
    endtask

    // Drive one cycle of inputs, check the combinational fetch interface,
    // clock it, then check every registered output against the model.
    task automatic applyStimulus(input bit rst, input bit stl, input bit br,
                                 input logic [PC_W-1:0] tgt, input bit rdy,
                                 input logic [INSTR_W-1:0] data);
        reset = rst; stall = stl; branch_taken = br;
        branch_target = tgt; imem_ready = rdy; imem_rdata = data;
        #1;
        if (m_known) begin
            checkOutput("imem_addr", imem_addr, m_pc);
            checkOutput("imem_req", imem_req, !(m_boot || m_halt));
        end
        @(posedge clk);
        modelStep(rst, stl, br, tgt, rdy, data);
        #1;
        checkOutput("ifid_valid", ifid_valid, m_valid);
        checkOutput("ifid_pc", ifid_pc, m_ipc);
        checkOutput("ifid_instr", ifid_instr, m_instr);
        checkOutput("halted", halted, m_halt);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_fetch", perf_fetch, m_fetch);
        checkOutput("perf_stall", perf_stall, m_stall);
        checkOutput("perf_bubble", perf_bubble, m_bubble);
`else
        checkOutput("perf_fetch", perf_fetch, 0);
        checkOutput("perf_stall", perf_stall, 0);
        checkOutput("perf_bubble", perf_bubble, 0);
`endif
    endtask

    initial begin
        bit                 r_rst, r_stl, r_br, r_rdy;
        logic [PC_W-1:0]    r_tgt;
        logic [INSTR_W-1:0] r_data;

        reset = 1; stall = 0; branch_taken = 0; branch_target = '0;
        imem_ready = 1; imem_rdata = D;

        // T1: reset, boot, sequential fetch
        applyStimulus(1, 0, 0, 0, 1, D);
        checkOutput("T1 reset ifid_valid", ifid_valid, 0);
        applyStimulus(0, 0, 0, 0, 1, D);
        checkOutput("T1 boot bubble", ifid_valid, 0);
        applyStimulus(0, 0, 0, 0, 1, D);
        checkOutput("T1 first valid", ifid_valid, 1);
        checkOutput("T1 first pc", ifid_pc, 0);
        checkOutput("T1 pc=4", imem_addr, 64'd4);
        applyStimulus(0, 0, 0, 0, 1, D);
        checkOutput("T1 pc=8", imem_addr, 64'd8);

        // T2: two stall cycles at pc=8
        applyStimulus(0, 1, 0, 0, 1, D);
        applyStimulus(0, 1, 0, 0, 1, D);
        checkOutput("T2 pc held", imem_addr, 64'd8);
        checkOutput("T2 ifid_pc held", ifid_pc, 64'd4);
        checkOutput("T2 ifid_valid held", ifid_valid, 1);
        applyStimulus(0, 0, 0, 0, 1, D);
        checkOutput("T2 release", ifid_pc, 64'd8);

        // T4: three wait states at pc=12
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 32'hDEAD_BEEF);
            checkOutput("T4 addr held", imem_addr, 64'd12);
            checkOutput("T4 bubble", ifid_valid, 0);
        end
        applyStimulus(0, 0, 0, 0, 1, 32'h1234_5678);
        checkOutput("T4 ready pc", ifid_pc, 64'd12);
        checkOutput("T4 ready instr", ifid_instr, 32'h1234_5678);

        // T3: redirect beats stall, misaligned target
        applyStimulus(0, 1, 1, 64'h43, 1, D);
        checkOutput("T3 flush", ifid_valid, 0);
        checkOutput("T3 pc aligned", imem_addr, 64'h40);
        applyStimulus(0, 0, 0, 0, 1, D);
        checkOutput("T3 target fetched", ifid_pc, 64'h40);

        // T5: end-of-program at pc=16, leave via branch, reset while halted
        applyStimulus(0, 0, 1, 64'h10, 1, D);
        applyStimulus(0, 0, 0, 0, 1, 32'h0);
        checkOutput("T5 halted", halted, 1);
        checkOutput("T5 pc held", imem_addr, 64'h10);
        applyStimulus(0, 1, 0, 0, 1, D);
        checkOutput("T5 stall ignored", halted, 1);
        checkOutput("T5 req low", imem_req, 0);
        applyStimulus(0, 0, 1, 64'h0, 1, D);
        checkOutput("T5 unhalt", halted, 0);
        applyStimulus(0, 0, 0, 0, 1, D);
        checkOutput("T5 refetch 0", ifid_pc, 64'h0);
        applyStimulus(0, 0, 0, 0, 1, 32'h0);
        applyStimulus(1, 0, 0, 0, 1, D);
        checkOutput("T5 reset clears halt", halted, 0);

        // Branch during boot, then PC wrap at the top of the address space
        applyStimulus(0, 0, 1, 64'h1237, 1, D);
        checkOutput("boot redirect", imem_addr, 64'h1234);
        applyStimulus(0, 0, 0, 0, 1, D);
        applyStimulus(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, D);
        applyStimulus(0, 0, 0, 0, 1, D);
        checkOutput("wrap pc", imem_addr, 64'h0);
        checkOutput("wrap ifid_pc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);

`ifdef FETCH_PERF_CNT_EN
        // T6: saturation of the fetch counter
        force dut.perf_fetch_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_fetch_q;
        m_fetch = 32'hFFFF_FFFF;
        applyStimulus(0, 0, 0, 0, 1, D);
        applyStimulus(0, 0, 0, 0, 1, D);
        checkOutput("T6 saturated", perf_fetch, 32'hFFFF_FFFF);
`endif

        // Randomized run
        for (int n = 0; n < 400; n++) begin
            r_rst  = ($urandom_range(0, 99) < 2);
            r_stl  = ($urandom_range(0, 99) < 25);
            r_br   = ($urandom_range(0, 99) < 10);
            r_rdy  = ($urandom_range(0, 99) < 75);
            r_tgt  = {$urandom, $urandom};
            r_data = ($urandom_range(0, 99) < 5) ? 32'h0 : ($urandom | 32'h1);
            applyStimulus(r_rst, r_stl, r_br, r_tgt, r_rdy, r_data);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
